// File: rtl/axi_pkg.sv
// Shared definitions for the single-beat AXI initiator: state encoding,
// response codes and the fixed burst/size attributes it drives.
package axi_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_WR      = 3'd1;
    localparam state_t ST_WR_RESP = 3'd2;
    localparam state_t ST_RD_ADDR = 3'd3;
    localparam state_t ST_RD_DATA = 3'd4;
    localparam state_t ST_RSP     = 3'd5;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;

    // States during which the transaction latency counter runs.
    function automatic logic is_busy(input state_t s);
        return (s == ST_WR) || (s == ST_WR_RESP) || (s == ST_RD_ADDR) || (s == ST_RD_DATA);
    endfunction

endpackage

// File: rtl/axi_wr_join.sv
// Joins the independent AW and W handshakes of one write; both_done rises in
// the cycle the later of the two completes, whatever the order.
module axi_wr_join (
    input  logic aclk,
    input  logic aresetn,
    input  logic clear,
    input  logic aw_hs,
    input  logic w_hs,
    output logic both_done
);

    logic aw_done;
    logic w_done;

    assign both_done = (aw_done | aw_hs) & (w_done | w_hs);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (clear || both_done) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            aw_done <= aw_done | aw_hs;
            w_done  <= w_done | w_hs;
        end
    end

endmodule

// File: rtl/axi_lite_master.sv
// Single-beat AXI initiator: turns one local read/write command at a time into
// AXI channel traffic and returns data, response code and latency.
module axi_lite_master
    import axi_pkg::*;
#(
    parameter int addr_width = 3,
    parameter int data_width = 32,
    parameter int strb       = 4,
    parameter int resp       = 2,
    parameter int lat_width  = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [addr_width-1:0] cmd_addr,
    input  logic [data_width-1:0] cmd_wdata,
    input  logic [strb-1:0]       cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [data_width-1:0] rsp_rdata,
    output logic [resp-1:0]       rsp_resp,
    output logic [lat_width-1:0]  rsp_latency,

    output logic [addr_width-1:0] awaddr,
    output logic [7:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic                  awvalid,
    input  logic                  awready,

    output logic [data_width-1:0] wdata,
    output logic [strb-1:0]       wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,

    input  logic [resp-1:0]       bresp,
    input  logic                  bvalid,
    output logic                  bready,

    output logic [addr_width-1:0] araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arvalid,
    input  logic                  arready,

    input  logic [data_width-1:0] rdata,
    input  logic [resp-1:0]       rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready
);

    state_t                 state;
    logic [lat_width-1:0]   lat_cnt;
    logic [lat_width-1:0]   lat_next;
    logic                   accept;
    logic                   aw_hs;
    logic                   w_hs;
    logic                   both_done;
    logic                   unused_rlast;

    assign awlen   = 8'd0;
    assign arlen   = 8'd0;
    assign awsize  = SIZE_4B;
    assign arsize  = SIZE_4B;
    assign awburst = BURST_INCR;
    assign arburst = BURST_INCR;
    assign wlast   = 1'b1;

    // Every transfer is a single beat, so the slave's rlast carries no information.
    assign unused_rlast = rlast;

    assign accept   = cmd_valid && cmd_ready;
    assign aw_hs    = awvalid && awready;
    assign w_hs     = wvalid && wready;
    assign lat_next = (&lat_cnt) ? lat_cnt : lat_cnt + lat_width'(1);

    axi_wr_join u_wr_join (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .clear     (accept),
        .aw_hs     (aw_hs),
        .w_hs      (w_hs),
        .both_done (both_done)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lat_cnt <= '0;
        end else if (accept) begin
            lat_cnt <= '0;
        end else if (is_busy(state)) begin
            lat_cnt <= lat_next;
        end
    end

    // The response is latched with lat_next so the handshake cycle itself is counted.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= ST_IDLE;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_write   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= '0;
            rsp_latency <= '0;
            awaddr      <= '0;
            awvalid     <= 1'b0;
            wdata       <= '0;
            wstrb       <= '0;
            wvalid      <= 1'b0;
            bready      <= 1'b0;
            araddr      <= '0;
            arvalid     <= 1'b0;
            rready      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        if (cmd_write) begin
                            awaddr  <= cmd_addr;
                            wdata   <= cmd_wdata;
                            wstrb   <= cmd_wstrb;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= ST_WR;
                        end else begin
                            araddr  <= cmd_addr;
                            arvalid <= 1'b1;
                            state   <= ST_RD_ADDR;
                        end
                    end
                end
                ST_WR: begin
                    if (aw_hs) awvalid <= 1'b0;
                    if (w_hs)  wvalid  <= 1'b0;
                    if (both_done) begin
                        bready <= 1'b1;
                        state  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (bvalid) begin
                        bready      <= 1'b0;
                        rsp_write   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_resp    <= bresp;
                        rsp_latency <= lat_next;
                        rsp_valid   <= 1'b1;
                        state       <= ST_RSP;
                    end
                end
                ST_RD_ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (rvalid) begin
                        rready      <= 1'b0;
                        rsp_write   <= 1'b0;
                        rsp_rdata   <= rdata;
                        rsp_resp    <= rresp;
                        rsp_latency <= lat_next;
                        rsp_valid   <= 1'b1;
                        state       <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master with a small configurable-delay AXI slave
// model whose ready/valid responses are driven on the falling clock edge.
module tb_axi_lite_master;

    logic        aclk;
    logic        aresetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [2:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  rsp_latency;
    logic [2:0]  awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst;
    logic        awvalid, awready, wvalid, wready, wlast;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, arvalid, arready, rvalid, rready, rlast;

    int n_cmp;
    int n_fail;

    // Slave model configuration and state
    int          aw_delay, w_delay, b_delay, ar_delay, r_delay;
    int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
    logic [1:0]  rresp_force;
    logic [31:0] mem [0:7];
    logic [2:0]  wr_addr, rd_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    int          b_count;

    axi_lite_master dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_latency(rsp_latency),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Handshakes are sampled on the rising edge, before the DUT's registers update.
    always @(posedge aclk) begin
        if (aresetn) begin
            if (awvalid && awready) wr_addr = awaddr;
            if (wvalid && wready) begin
                wr_data = wdata;
                wr_strb = wstrb;
            end
            if (arvalid && arready) rd_addr = araddr;
            if (bvalid && bready) begin
                for (int b = 0; b < 4; b++)
                    if (wr_strb[b]) mem[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
                b_count++;
            end
        end
    end

    always @(negedge aclk) begin
        if (!aresetn) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0;
            bresp = 0; rresp = 0; rdata = 0;
            aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        end else begin
            if (awvalid) begin awready = (aw_wait == aw_delay); aw_wait++; end
            else begin awready = 0; aw_wait = 0; end
            if (wvalid) begin wready = (w_wait == w_delay); w_wait++; end
            else begin wready = 0; w_wait = 0; end
            if (arvalid) begin arready = (ar_wait == ar_delay); ar_wait++; end
            else begin arready = 0; ar_wait = 0; end
            if (bready) begin bvalid = (b_wait == b_delay); b_wait++; end
            else begin bvalid = 0; b_wait = 0; end
            bresp = 2'b00;
            if (rready) begin rvalid = (r_wait == r_delay); r_wait++; end
            else begin rvalid = 0; r_wait = 0; end
            rdata = rvalid ? mem[rd_addr] : 32'd0;
            rresp = rvalid ? rresp_force : 2'b00;
            rlast = rvalid;
        end
    end

    task automatic issue_cmd(input logic wr, input logic [2:0] addr, input logic [31:0] data,
                             output logic ok);
        int n;
        n = 0;
        @(negedge aclk);
        while (cmd_ready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
        ok = (cmd_ready === 1'b1);
        if (ok) begin
            cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = 4'hF;
            @(posedge aclk);
            #1 cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_rsp(output logic ok);
        int n;
        n = 0;
        @(negedge aclk);
        while (rsp_valid !== 1'b1 && n < 100) begin @(negedge aclk); n++; end
        ok = (rsp_valid === 1'b1);
    endtask

    task automatic consume_rsp();
        rsp_ready = 1'b1;
        @(posedge aclk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge aclk);
        #1;
        n_cmp++;
        if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready} !== 7'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_handshakes: got %b expected 0000000",
                     {awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready});
        end
        n_cmp++;
        if ({awaddr, wdata, araddr, rsp_rdata, rsp_resp, rsp_latency, rsp_write} !== 81'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_datapath: got %h expected 0",
                     {awaddr, wdata, araddr, rsp_rdata, rsp_resp, rsp_latency, rsp_write});
        end
        n_cmp++;
        if ({awlen, awsize, awburst, arlen, arsize, arburst, wlast} !== {8'd0, 3'b010, 2'b01, 8'd0, 3'b010, 2'b01, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL const_attrs: got %h expected %h",
                     {awlen, awsize, awburst, arlen, arsize, arburst, wlast},
                     {8'd0, 3'b010, 2'b01, 8'd0, 3'b010, 2'b01, 1'b1});
        end
        aresetn = 1'b1;
        @(negedge aclk);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_release_cmd_ready: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_write_read();
        logic ok;
        issue_cmd(1'b1, 3'd1, 32'd5, ok);
        if (ok) wait_rsp(ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL wr1_timeout: got %b expected 1", ok); end
        n_cmp++;
        if ({rsp_write, rsp_resp, rsp_rdata, rsp_latency} !== {1'b1, 2'b00, 32'd0, 8'd2}) begin
            n_fail++;
            $display("[TB] FAIL wr1_rsp: got w=%b resp=%b rdata=%0d lat=%0d expected w=1 resp=00 rdata=0 lat=2",
                     rsp_write, rsp_resp, rsp_rdata, rsp_latency);
        end
        consume_rsp();
        issue_cmd(1'b0, 3'd1, 32'd0, ok);
        if (ok) wait_rsp(ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL rd1_timeout: got %b expected 1", ok); end
        n_cmp++;
        if ({rsp_write, rsp_resp, rsp_rdata, rsp_latency} !== {1'b0, 2'b00, 32'd5, 8'd2}) begin
            n_fail++;
            $display("[TB] FAIL rd1_rsp: got w=%b resp=%b rdata=%0d lat=%0d expected w=0 resp=00 rdata=5 lat=2",
                     rsp_write, rsp_resp, rsp_rdata, rsp_latency);
        end
        consume_rsp();
    endtask

    task automatic test_data_first();
        logic ok;
        int   b_before;
        b_before = b_count;
        aw_delay = 2; w_delay = 0;
        issue_cmd(1'b1, 3'd7, 32'hCAFE_0007, ok);
        if (ok) wait_rsp(ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL data_first_timeout: got %b expected 1", ok); end
        n_cmp++;
        if ({rsp_write, rsp_resp, rsp_latency} !== {1'b1, 2'b00, 8'd4}) begin
            n_fail++;
            $display("[TB] FAIL data_first_rsp: got w=%b resp=%b lat=%0d expected w=1 resp=00 lat=4",
                     rsp_write, rsp_resp, rsp_latency);
        end
        consume_rsp();
        n_cmp++;
        if (b_count - b_before !== 1) begin
            n_fail++;
            $display("[TB] FAIL data_first_b_count: got %0d expected 1", b_count - b_before);
        end
        aw_delay = 0;
    endtask

    task automatic test_addr_first();
        logic ok;
        aw_delay = 0; w_delay = 2;
        issue_cmd(1'b1, 3'd6, 32'h1234_5678, ok);
        if (ok) wait_rsp(ok);
        n_cmp++;
        if ({ok, rsp_write, rsp_resp, rsp_latency} !== {1'b1, 1'b1, 2'b00, 8'd4}) begin
            n_fail++;
            $display("[TB] FAIL addr_first_rsp: got ok=%b w=%b resp=%b lat=%0d expected ok=1 w=1 resp=00 lat=4",
                     ok, rsp_write, rsp_resp, rsp_latency);
        end
        consume_rsp();
        w_delay = 0;
        issue_cmd(1'b0, 3'd6, 32'd0, ok);
        if (ok) wait_rsp(ok);
        n_cmp++;
        if ({ok, rsp_rdata} !== {1'b1, 32'h1234_5678}) begin
            n_fail++;
            $display("[TB] FAIL addr_first_readback: got ok=%b rdata=%h expected ok=1 rdata=12345678", ok, rsp_rdata);
        end
        consume_rsp();
    endtask

    task automatic test_simultaneous();
        logic ok;
        issue_cmd(1'b1, 3'd2, 32'd9, ok);
        @(negedge aclk);
        n_cmp++;
        if ({ok, awvalid, wvalid, bready} !== 4'b1110) begin
            n_fail++;
            $display("[TB] FAIL simul_first_cycle: got ok/aw/w/b=%b expected 1110", {ok, awvalid, wvalid, bready});
        end
        @(negedge aclk);
        n_cmp++;
        if ({awvalid, wvalid, bready} !== 3'b001) begin
            n_fail++;
            $display("[TB] FAIL simul_next_cycle: got aw/w/b=%b expected 001", {awvalid, wvalid, bready});
        end
        wait_rsp(ok);
        n_cmp++;
        if ({ok, rsp_write, rsp_resp, rsp_latency} !== {1'b1, 1'b1, 2'b00, 8'd2}) begin
            n_fail++;
            $display("[TB] FAIL simul_rsp: got ok=%b w=%b resp=%b lat=%0d expected ok=1 w=1 resp=00 lat=2",
                     ok, rsp_write, rsp_resp, rsp_latency);
        end
        consume_rsp();
    endtask

    task automatic test_read_empty_and_err();
        logic ok;
        issue_cmd(1'b0, 3'd5, 32'd0, ok);
        if (ok) wait_rsp(ok);
        n_cmp++;
        if ({ok, rsp_write, rsp_resp, rsp_rdata} !== {1'b1, 1'b0, 2'b00, 32'd0}) begin
            n_fail++;
            $display("[TB] FAIL rd_empty: got ok=%b w=%b resp=%b rdata=%h expected ok=1 w=0 resp=00 rdata=0",
                     ok, rsp_write, rsp_resp, rsp_rdata);
        end
        consume_rsp();
        rresp_force = 2'b10;
        r_delay = 3;
        issue_cmd(1'b0, 3'd1, 32'd0, ok);
        if (ok) wait_rsp(ok);
        n_cmp++;
        if ({ok, rsp_resp, rsp_rdata, rsp_latency} !== {1'b1, 2'b10, 32'd5, 8'd5}) begin
            n_fail++;
            $display("[TB] FAIL rd_slverr: got ok=%b resp=%b rdata=%0d lat=%0d expected ok=1 resp=10 rdata=5 lat=5",
                     ok, rsp_resp, rsp_rdata, rsp_latency);
        end
        consume_rsp();
        rresp_force = 2'b00;
        r_delay = 0;
    endtask

    task automatic test_rsp_hold();
        logic ok;
        issue_cmd(1'b1, 3'd2, 32'hA5A5_0001, ok);
        if (ok) wait_rsp(ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_timeout: got %b expected 1", ok); end
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 3'd2;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({rsp_valid, cmd_ready, arvalid, rsp_write, rsp_resp, rsp_rdata, rsp_latency}
                !== {1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 32'd0, 8'd2}) begin
                n_fail++;
                $display("[TB] FAIL hold_cycle%0d: got v/cr/ar/w=%b resp=%b rdata=%h lat=%0d expected 1001 resp=00 rdata=0 lat=2",
                         i, {rsp_valid, cmd_ready, arvalid, rsp_write}, rsp_resp, rsp_rdata, rsp_latency);
            end
            @(negedge aclk);
        end
        consume_rsp();
        n_cmp++;
        if ({rsp_valid, cmd_ready, arvalid} !== 3'b010) begin
            n_fail++;
            $display("[TB] FAIL hold_after_handshake: got v/cr/ar=%b expected 010", {rsp_valid, cmd_ready, arvalid});
        end
        @(posedge aclk);
        #1 cmd_valid = 1'b0;
        n_cmp++;
        if ({cmd_ready, arvalid, araddr} !== {1'b0, 1'b1, 3'd2}) begin
            n_fail++;
            $display("[TB] FAIL hold_second_accept: got cr=%b ar=%b araddr=%0d expected cr=0 ar=1 araddr=2",
                     cmd_ready, arvalid, araddr);
        end
        wait_rsp(ok);
        n_cmp++;
        if ({ok, rsp_rdata} !== {1'b1, 32'hA5A5_0001}) begin
            n_fail++;
            $display("[TB] FAIL hold_readback: got ok=%b rdata=%h expected ok=1 rdata=a5a50001", ok, rsp_rdata);
        end
        consume_rsp();
    endtask

    task automatic test_reset_mid_txn();
        logic ok;
        int   n;
        b_delay = 20;
        issue_cmd(1'b1, 3'd4, 32'd7, ok);
        n = 0;
        @(negedge aclk);
        while (bready !== 1'b1 && n < 20) begin @(negedge aclk); n++; end
        n_cmp++;
        if ({ok, bready} !== 2'b11) begin
            n_fail++;
            $display("[TB] FAIL mid_reach_wr_resp: got ok=%b bready=%b expected 11", ok, bready);
        end
        #2 aresetn = 1'b0;
        #1;
        n_cmp++;
        if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready, awaddr, wdata} !== 42'd0) begin
            n_fail++;
            $display("[TB] FAIL mid_async_reset: got %h expected 0",
                     {awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready, awaddr, wdata});
        end
        b_delay = 0;
        repeat (2) @(negedge aclk);
        #1 aresetn = 1'b1;
        issue_cmd(1'b1, 3'd3, 32'd20, ok);
        if (ok) wait_rsp(ok);
        n_cmp++;
        if ({ok, rsp_write, rsp_resp, rsp_latency} !== {1'b1, 1'b1, 2'b00, 8'd2}) begin
            n_fail++;
            $display("[TB] FAIL post_reset_write: got ok=%b w=%b resp=%b lat=%0d expected ok=1 w=1 resp=00 lat=2",
                     ok, rsp_write, rsp_resp, rsp_latency);
        end
        consume_rsp();
        issue_cmd(1'b0, 3'd3, 32'd0, ok);
        if (ok) wait_rsp(ok);
        n_cmp++;
        if ({ok, rsp_rdata} !== {1'b1, 32'd20}) begin
            n_fail++;
            $display("[TB] FAIL post_reset_readback: got ok=%b rdata=%0d expected ok=1 rdata=20", ok, rsp_rdata);
        end
        consume_rsp();
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; b_count = 0;
        aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        rresp_force = 2'b00;
        wr_addr = 0; rd_addr = 0; wr_data = 0; wr_strb = 0;
        for (int i = 0; i < 8; i++) mem[i] = 32'd0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
        rvalid = 0; rdata = 0; rresp = 0; rlast = 0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 0;
        aresetn = 1'b0;

        test_reset();
        test_write_read();
        test_data_first();
        test_addr_first();
        test_simultaneous();
        test_read_empty_and_err();
        test_rsp_hold();
        test_reset_mid_txn();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- Synthesizable single-beat AXI initiator; the requester end of the channel set that axi_slave responds to.
- Accepts simple read/write commands from a local requester and drives the five AXI channels, one transaction at a time.
- Returns read data, response code and measured latency to the requester.
- Sits between test/CPU-side logic and axi_slave in the subsystem.

Parameters:
- addr_width, 3, AXI address width (matches axi_slave).
- data_width, 32, data bus width.
- strb, 4, byte strobe width (data_width/8).
- resp, 2, response code width.
- lat_width, 8, latency counter width.

Ports:
- aclk  input  1  clock, rising edge.
- aresetn  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  command accepted when both are high.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  addr_width  target address.
- cmd_wdata  input  data_width  write data.
- cmd_wstrb  input  strb  write strobes.
- rsp_valid  output  1  completion available.
- rsp_ready  input  1  requester consumes completion.
- rsp_write  output  1  completion is for a write.
- rsp_rdata  output  data_width  read data; 0 for writes.
- rsp_resp  output  resp  bresp or rresp captured from the slave.
- rsp_latency  output  lat_width  cycles from AXI valid assertion to response handshake, saturating.
- awaddr  output  addr_width; awlen  output  8; awsize  output  3; awburst  output  2.
- awvalid  output  1; awready  input  1.
- wdata  output  data_width; wstrb  output  strb; wlast  output  1; wvalid  output  1; wready  input  1.
- bresp  input  resp; bvalid  input  1; bready  output  1.
- araddr  output  addr_width; arlen  output  8; arsize  output  3; arburst  output  2.
- arvalid  output  1; arready  input  1.
- rdata  input  data_width; rresp  input  resp; rlast  input  1; rvalid  input  1; rready  output  1.
- Slave sideband inputs (id/lock/cache/prot/qos/region/user) are tied 0 at integration; they are not ports of this block.

Behaviour:
- Reset (async, aresetn low): state IDLE; all valid/ready outputs 0; address/data/rsp outputs 0; latency counter 0.
- Constants driven: awlen = arlen = 0, awsize = arsize = 3'b010, awburst = arburst = 2'b01, wlast = 1.
- States: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE: cmd_ready = 1. On cmd_valid, capture addr/data/strb/write into registers.
  - Write: next cycle awvalid = wvalid = 1, state WR.
  - Read: next cycle arvalid = 1, state RD_ADDR.
- WR: awvalid and wvalid are held independently until their own handshake, then each drops the next cycle.
  - Handshakes may occur in the same cycle or in either order (address-first, data-first, simultaneous); all three are legal.
  - When both handshakes have completed, bready = 1 and state WR_RESP.
  - awaddr/wdata stay stable while their valid is high.
- WR_RESP: on bvalid && bready, capture bresp, set rsp_write = 1 and rsp_rdata = 0, drop bready, state RSP.
- RD_ADDR: on arready, drop arvalid, set rready = 1, state RD_DATA.
- RD_DATA: on rvalid && rready, capture rdata/rresp, set rsp_write = 0, drop rready, state RSP. rlast is ignored (single beat).
- RSP: rsp_valid = 1; outputs held stable until rsp_ready; then rsp_valid = 0 and state IDLE.
  - cmd_ready is 0 outside IDLE; a new command is first accepted the cycle after the rsp handshake.
- Latency counter:
  - Clears on command accept.
  - Increments each cycle in WR, WR_RESP, RD_ADDR, RD_DATA.
  - Saturates at all-ones and is latched into rsp_latency on entry to RSP.
- No timeout: the block waits indefinitely for the slave, as AXI requires.
- Reset asserted mid-transaction aborts immediately to the reset values; the slave is reset by the same aresetn.
- Valid never depends combinationally on ready; all AXI outputs are registered.

Decomposition:
- Shared package axi_pkg holds:
  - State encoding.
  - Response codes OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11.
  - Burst code INCR = 2'b01.
  - Size code 3'b010.
- One natural sub-module: axi_wr_join, which tracks the independent aw/w handshake completion and flags both_done. Everything else stays flat.

Test Plan:
- Write addr 1, data 32'd5, axi_slave attached → awvalid/wvalid both accepted; rsp_valid with rsp_write = 1, rsp_resp = 2'b00. A following read of addr 1 returns rsp_rdata = 5, rsp_resp = 0.
- Bench slave model with wready 2 cycles before awready (data-first) → single B accepted, rsp_resp = 0, rsp_latency = 4 under a fixed delay pattern.
- Simultaneous awready/wready in the first valid cycle → both valids drop next cycle, bready = 1 the same next cycle.
- Read addr 5 (never written) → rsp_rdata = 0 and rsp_resp matching the slave's empty-location code. Bench slave returning rresp = 2'b10 → rsp_resp = 2'b10.
- Hold rsp_ready = 0 for 5 cycles → rsp outputs stable and cmd_ready = 0 throughout; a second cmd_valid is not accepted until after the rsp handshake.
- Assert aresetn low while in WR_RESP → all valid/ready outputs 0 asynchronously, state IDLE. After release, a write to addr 3 with data 32'd20 completes normally.
